tournament_branch_predictor: RTL and testbench
==============================================

Name: tournament_branch_predictor

Overview:
Parametrised tournament (local/global/chooser) conditional branch predictor for the fetch stage, second generation. Adds configurable table and counter widths, optional gshare indexing of the global PHT, and a per-PC chooser. The global history register is updated speculatively at prediction time and repaired on mispredict using a checkpoint that travels down the pipeline with the branch. Tables are cleared by a sequential init walk after reset rather than in a single cycle.

Parameters:
PC_INDEX_BITS, 10, index width of the local history table and the chooser; the index is pc[PC_INDEX_BITS+1:2]
LHIST_BITS, 10, local history length; the local PHT has 2^LHIST_BITS entries
GHR_BITS, 12, global history length; the global PHT has 2^GHR_BITS entries
CTR_BITS, 2, width of the local and global PHT saturating counters (>=2)
CHOOSER_BITS, 2, width of the chooser saturating counters (>=2)
USE_GSHARE, 1, 1: global index = GHR xor pc[GHR_BITS+1:2]; 0: global index = GHR

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ready  out  1  high once the init walk is complete
pred_valid  in  1  fetch requests a prediction this cycle
pred_pc  in  32  PC of the branch being predicted
pred_taken  out  1  final prediction (combinational from pred_pc and current state)
pred_ghr  out  GHR_BITS  GHR value before this prediction's speculative shift (checkpoint)
upd_valid  in  1  branch resolved this cycle
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_ghr  in  GHR_BITS  checkpoint captured with the branch when it was predicted
upd_mispredict  in  1  resolved outcome differs from the predicted outcome

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: GHR<=0; init index<=0; state<=INIT; ready=0. Asserting reset in any state, including mid-INIT, restarts the walk from index 0.
- INIT: one index per cycle, index i runs 0..D-1 with D = max(2^PC_INDEX_BITS, 2^LHIST_BITS, 2^GHR_BITS).
  - Each cycle writes every table whose size is greater than i.
  - Local history entries <= 0.
  - PHT counters <= 2^(CTR_BITS-1)-1 (weakly not-taken).
  - Chooser counters <= 2^(CHOOSER_BITS-1) (weakly prefers global).
- INIT to RUN: after writing index D-1, state moves to RUN; ready=1 from the next cycle.
- While INIT: pred_taken=0, pred_ghr=0; pred_valid and upd_valid are ignored and the GHR is held.
- Predict (RUN, combinational, asynchronous table read):
  - lh = LHT[pc_idx]; local = LPHT[lh] MSB.
  - gidx per USE_GSHARE using the current GHR; global = GPHT[gidx] MSB.
  - pred_taken = CHOOSER[pc_idx] MSB ? global : local.
- Speculative history: on pred_valid&ready, GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
- Update (RUN, upd_valid), all writes at the clock edge:
  - Local side: lh_u = LHT[upd_pc idx]; LHT <= {lh_u[LHIST_BITS-2:0], upd_taken}; LPHT[lh_u] saturating ±1 toward upd_taken.
  - Global side: gidx_u is computed from upd_ghr and upd_pc, never from the live GHR; GPHT[gidx_u] saturating ±1.
  - Chooser, indexed by upd_pc idx: recompute local_u and global_u from the pre-update counters. Only if they differ, move one step toward the correct component (global correct: +1; local correct: -1), saturating at 0 and max.
- Mispredict: upd_valid&upd_mispredict sets GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}. This has priority over a same-cycle speculative shift, whose effect is discarded.
- Same-cycle predict and update to the same entry: the prediction sees pre-update contents (read-before-write).
- Counters never wrap, in either direction.
- upd_mispredict without upd_valid is ignored.

Test Plan:
- Reset with defaults: ready=0 for exactly 4096 cycles after reset deasserts, then ready=1; pred_taken=0 throughout INIT; first RUN prediction at any PC = 0.
- Reset reasserted at INIT cycle 100: ready stays 0 for a full 4096 cycles after the second deassertion.
- Loop pc=0x100, each iteration: predict, then update with upd_taken=1, upd_ghr=pred_ghr, upd_mispredict=(pred_taken!=1) → pred_taken=1 by iteration 16 and on every iteration thereafter.
- Recovery: GHR=0, three predictions at pc=0x200 all return 0 (pred_ghr 0x000,0x000,0x000); then upd_mispredict with upd_ghr=0x000, upd_taken=1, plus a same-cycle pred_valid → next pred_ghr=0x001.
- Saturation: 6 not-taken updates to one PHT entry, then 1 taken update → prediction still 0; 2 more taken updates → prediction 1.
- USE_GSHARE=0 vs 1, trained identically on pc=0x104/0x204 with opposite outcomes: gshare variant predicts both correctly after training, while the non-gshare variant aliases and mispredicts one of them.

Source files
------------

// File: rtl/tournament_branch_predictor.sv
// tournament_branch_predictor: local/global/chooser conditional branch predictor with speculative GHR and checkpoint repair
module tournament_branch_predictor #(
    parameter int PC_INDEX_BITS = 10,
    parameter int LHIST_BITS    = 10,
    parameter int GHR_BITS      = 12,
    parameter int CTR_BITS      = 2,
    parameter int CHOOSER_BITS  = 2,
    parameter int USE_GSHARE    = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict
);
    localparam int IW_A = PC_INDEX_BITS > LHIST_BITS ? PC_INDEX_BITS : LHIST_BITS;
    localparam int IW   = IW_A > GHR_BITS ? IW_A : GHR_BITS;
    localparam logic [IW-1:0]           LAST     = '1;
    localparam logic [CTR_BITS-1:0]     CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CHOOSER_BITS-1:0] CHO_INIT = {1'b1, {(CHOOSER_BITS-1){1'b0}}};

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [GHR_BITS-1:0]     ghr;
    logic [LHIST_BITS-1:0]   lht  [2**PC_INDEX_BITS];
    logic [CTR_BITS-1:0]     lpht [2**LHIST_BITS];
    logic [CTR_BITS-1:0]     gpht [2**GHR_BITS];
    logic [CHOOSER_BITS-1:0] cho  [2**PC_INDEX_BITS];

    logic [PC_INDEX_BITS-1:0] p_idx, u_idx;
    logic [GHR_BITS-1:0]      p_gidx, u_gidx;
    logic [LHIST_BITS-1:0]    p_lh, u_lh;
    logic                     p_local, p_global, u_local, u_global;
    logic                     unused;

    function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
        return up ? (&c ? c : c + 1'b1) : (|c ? c - 1'b1 : c);
    endfunction

    function automatic logic [CHOOSER_BITS-1:0] cho_step(input logic [CHOOSER_BITS-1:0] c, input logic up);
        return up ? (&c ? c : c + 1'b1) : (|c ? c - 1'b1 : c);
    endfunction

    assign p_idx    = pred_pc[PC_INDEX_BITS+1:2];
    assign p_gidx   = USE_GSHARE != 0 ? ghr ^ pred_pc[GHR_BITS+1:2] : ghr;
    assign p_lh     = lht[p_idx];
    assign p_local  = lpht[p_lh][CTR_BITS-1];
    assign p_global = gpht[p_gidx][CTR_BITS-1];

    assign pred_taken = ready & (cho[p_idx][CHOOSER_BITS-1] ? p_global : p_local);
    assign pred_ghr   = ready ? ghr : '0;

    // Training indexes come from the resolved branch and its checkpoint, never the live GHR
    assign u_idx    = upd_pc[PC_INDEX_BITS+1:2];
    assign u_gidx   = USE_GSHARE != 0 ? upd_ghr ^ upd_pc[GHR_BITS+1:2] : upd_ghr;
    assign u_lh     = lht[u_idx];
    assign u_local  = lpht[u_lh][CTR_BITS-1];
    assign u_global = gpht[u_gidx][CTR_BITS-1];

    assign unused = ^{pred_pc, upd_pc, upd_ghr};

    // Control: init walk sequencing, ready flag, speculative GHR shift and mispredict repair
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            idx   <= '0;
            ready <= 1'b0;
            ghr   <= '0;
        end else if (state == INIT) begin
            idx <= idx + 1'b1;
            if (idx == LAST) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else if (upd_valid && upd_mispredict) begin
            ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
        end else if (pred_valid) begin
            ghr <= {ghr[GHR_BITS-2:0], pred_taken};
        end
    end

    // Tables: cleared one index per cycle while not ready, trained by resolved branches in RUN
    always_ff @(posedge clk) begin
        if (!ready) begin
            if ((idx >> PC_INDEX_BITS) == '0) begin
                lht[idx[PC_INDEX_BITS-1:0]] <= '0;
                cho[idx[PC_INDEX_BITS-1:0]] <= CHO_INIT;
            end
            if ((idx >> LHIST_BITS) == '0)
                lpht[idx[LHIST_BITS-1:0]] <= CTR_INIT;
            if ((idx >> GHR_BITS) == '0)
                gpht[idx[GHR_BITS-1:0]] <= CTR_INIT;
        end else if (upd_valid && !reset) begin
            lht[u_idx]   <= {u_lh[LHIST_BITS-2:0], upd_taken};
            lpht[u_lh]   <= ctr_step(lpht[u_lh], upd_taken);
            gpht[u_gidx] <= ctr_step(gpht[u_gidx], upd_taken);
            if (u_local != u_global)
                cho[u_idx] <= cho_step(cho[u_idx], u_global == upd_taken);
        end
    end
endmodule

// File: tb/tb_tournament_branch_predictor.sv
// tb_tournament_branch_predictor: directed and random checks of the tournament predictor against a table-level model
module tb_tournament_branch_predictor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pred_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, upd_mispredict = 1'b0;
    logic [31:0] pred_pc = '0, upd_pc = '0;
    logic [11:0] upd_ghr = '0;
    logic        ready, pred_taken, ready2, pred_taken2;
    logic [11:0] pred_ghr, pred_ghr2;

    int vec = 0, errs = 0;
    int m_lht [1024];
    int m_lpht[1024];
    int m_gpht[4096];
    int m_cho [1024];
    int m_ghr;

    always #5 clk = ~clk;

    tournament_branch_predictor dut (
        .clk(clk), .reset(reset), .ready(ready),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict)
    );

    tournament_branch_predictor #(.USE_GSHARE(0)) dut_ng (
        .clk(clk), .reset(reset), .ready(ready2),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken2), .pred_ghr(pred_ghr2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 1024; i++) begin
            m_lht[i]  = 0;
            m_lpht[i] = 1;
            m_cho[i]  = 2;
        end
        for (int i = 0; i < 4096; i++) m_gpht[i] = 1;
        m_ghr = 0;
    endfunction

    function automatic int sat(input int v, input int d);
        return v + d < 0 ? 0 : (v + d > 3 ? 3 : v + d);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        int i  = int'(pc / 4 % 1024);
        int gi = int'(pc / 4 % 4096) ^ m_ghr;
        return m_cho[i] >= 2 ? m_gpht[gi] >= 2 : m_lpht[m_lht[i]] >= 2;
    endfunction

    function automatic void m_train(input logic [31:0] pc, input bit t, input int gh);
        int i  = int'(pc / 4 % 1024);
        int lh = m_lht[i];
        int gi = int'(pc / 4 % 4096) ^ gh;
        bit lu = m_lpht[lh] >= 2;
        bit gu = m_gpht[gi] >= 2;
        m_lht[i]   = (lh * 2 + int'(t)) % 1024;
        m_lpht[lh] = sat(m_lpht[lh], t ? 1 : -1);
        m_gpht[gi] = sat(m_gpht[gi], t ? 1 : -1);
        if (lu != gu) m_cho[i] = sat(m_cho[i], gu == t ? 1 : -1);
    endfunction

    function automatic logic [31:0] rpc();
        return 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3)) * 1024 + ($urandom & 32'hFFFF_0003);
    endfunction

    task automatic idle_inputs();
        pred_valid = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        pred_pc = '0; upd_pc = '0; upd_ghr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic wait_ready(output int n);
        bit bad = 1'b0;
        n = 0;
        while (n < 6000) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) break;
            if (pred_taken || pred_taken2 || pred_ghr != 0 || pred_ghr2 != 0 || ready2) bad = 1'b1;
            pred_valid = 1'($urandom); pred_pc = $urandom;
            upd_valid = 1'($urandom); upd_pc = $urandom; upd_taken = 1'($urandom);
            upd_ghr = 12'($urandom); upd_mispredict = 1'($urandom);
        end
        idle_inputs();
        chk("init_quiet", 32'(bad), 32'd0);
        chk("ready_ng", 32'(ready2), 32'd1);
    endtask

    task automatic step(input bit pv, input logic [31:0] ppc, input bit uv, input logic [31:0] upc,
                        input bit ut, input int ughr, input bit um,
                        output bit got, output bit got2, output logic [11:0] gg, output bit ep, output int eg);
        @(negedge clk);
        pred_valid = pv; pred_pc = ppc; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_ghr = 12'(ughr); upd_mispredict = um;
        #1;
        ep = m_pred(ppc);
        eg = m_ghr;
        got = pred_taken; got2 = pred_taken2; gg = pred_ghr;
        chk("pred_taken", 32'(pred_taken), 32'(ep));
        chk("pred_ghr", 32'(pred_ghr), 32'(eg));
        @(posedge clk);
        if (uv) m_train(upc, ut, ughr);
        if (uv && um) m_ghr = (ughr * 2 + int'(ut)) % 4096;
        else if (pv) m_ghr = (m_ghr * 2 + int'(ep)) % 4096;
    endtask

    initial begin
        int n, eg;
        bit g, g2, ep;
        logic [11:0] gg;
        do_reset();
        wait_ready(n);
        chk("init_len", 32'(n), 32'd4096);
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        chk("ready_mid_init", 32'(ready), 32'd0);
        do_reset();
        wait_ready(n);
        chk("init_len_restart", 32'(n), 32'd4096);
        step(0, rpc(), 0, 0, 0, 0, 0, g, g2, gg, ep, eg);
        chk("first_pred", 32'(g), 32'd0);
        repeat (6) step(0, 32'h3C0, 1, 32'h3C0, 0, 0, 0, g, g2, gg, ep, eg);
        step(0, 32'h3C0, 1, 32'h3C0, 1, 0, 0, g, g2, gg, ep, eg);
        chk("sat_after_6nt", 32'(g), 32'd0);
        step(0, 32'h3C0, 0, 0, 0, 0, 0, g, g2, gg, ep, eg);
        chk("sat_after_1t", 32'(g), 32'd0);
        repeat (2) step(0, 32'h3C0, 1, 32'h3C0, 1, 0, 0, g, g2, gg, ep, eg);
        step(0, 32'h3C0, 0, 0, 0, 0, 0, g, g2, gg, ep, eg);
        chk("sat_after_3t", 32'(g), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h200, 0, 0, 0, 0, 0, g, g2, gg, ep, eg);
            chk("recov_pred", 32'(g), 32'd0);
            chk("recov_ghr", 32'(gg), 32'd0);
        end
        step(1, 32'h200, 1, 32'h200, 1, 0, 1, g, g2, gg, ep, eg);
        step(0, 32'h200, 0, 0, 0, 0, 0, g, g2, gg, ep, eg);
        chk("recov_repair", 32'(gg), 32'h001);
        for (int it = 1; it <= 40; it++) begin
            step(1, 32'h100, 0, 0, 0, 0, 0, g, g2, gg, ep, eg);
            if (it >= 16) chk("loop_taken", 32'(g), 32'd1);
            step(0, 32'h100, 1, 32'h100, 1, eg, ep != 1'b1, g, g2, gg, ep, eg);
        end
        for (int r = 0; r < 500; r++)
            step(1'($urandom), rpc(), 1'($urandom), rpc(), 1'($urandom), int'($urandom_range(0, 4095)),
                 1'($urandom), g, g2, gg, ep, eg);
        do_reset();
        wait_ready(n);
        chk("init_len_gshare", 32'(n), 32'd4096);
        for (int r = 0; r < 3; r++) begin
            step(0, 32'h104, 1, 32'h104, 1, 0, 0, g, g2, gg, ep, eg);
            step(0, 32'h204, 1, 32'h204, 0, 0, 0, g, g2, gg, ep, eg);
        end
        step(0, 32'h104, 0, 0, 0, 0, 0, g, g2, gg, ep, eg);
        chk("gshare_104", 32'(g), 32'd1);
        chk("nogshare_104_alias", 32'(g2), 32'd0);
        step(0, 32'h204, 0, 0, 0, 0, 0, g, g2, gg, ep, eg);
        chk("gshare_204", 32'(g), 32'd0);
        chk("nogshare_204", 32'(g2), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
